// File: rtl/cdc_clear_ctrl_pkg.sv
// rtl/cdc_clear_ctrl_pkg.sv - state encoding and constants for the FIFO clear initiator
package cdc_clear_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    ISSUE,
    WAIT,
    DONE
  } clr_state_e;

  // Longest time a stalled beat is allowed to hold off a clear round.
  localparam int QuiesceMax = 16;

endpackage

// File: rtl/cdc_fifo_clear_initiator_counter.sv
// rtl/cdc_fifo_clear_initiator_counter.sv - free-running up counter with synchronous clear
module cdc_fifo_clear_initiator_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Clear wins over increment so a counter can be restarted on the entry cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cdc_fifo_clear_initiator.sv
// rtl/cdc_fifo_clear_initiator.sv - source-side controller driving a CDC FIFO clear round
module cdc_fifo_clear_initiator
  import cdc_clear_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_req_i,
  output logic                 clear_busy_o,
  output logic                 clear_done_o,
  output logic                 clear_timeout_o,
  output logic [CNT_WIDTH-1:0] clear_count_o,
  input  logic                 up_valid_i,
  output logic                 up_ready_o,
  output logic                 fifo_valid_o,
  input  logic                 fifo_ready_i,
  output logic                 fifo_clear_o,
  input  logic                 fifo_clear_pending_i
);

  localparam int TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TmoW-1:0] TmoLast =
    TmoW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam int QW = $clog2(QuiesceMax + 1);
  localparam logic [QW-1:0] QLast = QW'(QuiesceMax - 1);

  clr_state_e state_q, state_d;

  logic                 req_q, rerun_q, seen_q, timeout_q, stall_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [TmoW-1:0]      tmo_cnt;
  logic [QW-1:0]        q_cnt;

  logic req, pass, done_normal, tmo_hit, q_exit, rerun;

  // The counter clears on the ISSUE entry and counts ISSUE as well, so the
  // value seen in WAIT is the number of cycles since the clear pulse.
  cdc_fifo_clear_initiator_counter #(.WIDTH(TmoW)) u_tmo_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr (state_d == ISSUE),
    .inc ((state_q == ISSUE) || (state_q == WAIT)),
    .cnt (tmo_cnt)
  );

  cdc_fifo_clear_initiator_counter #(.WIDTH(QW)) u_quiesce_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr ((state_d == QUIESCE) && (state_q != QUIESCE)),
    .inc (state_q == QUIESCE),
    .cnt (q_cnt)
  );

  assign req          = req_q | clear_req_i;
  assign rerun        = rerun_q | clear_req_i;
  assign pass         = (state_q == IDLE) || (state_q == QUIESCE);
  assign fifo_valid_o = pass & up_valid_i;
  assign up_ready_o   = pass & fifo_ready_i;
  assign done_normal  = seen_q & ~fifo_clear_pending_i;
  assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= TmoLast);
  assign q_exit       = (up_valid_i & fifo_ready_i) | ~up_valid_i | (q_cnt == QLast);
  assign clear_count_o = count_q;

  // Next-state decode; the clear pulse and done strobes come straight from the state.
  always_comb begin
    state_d         = state_q;
    fifo_clear_o    = 1'b0;
    clear_done_o    = 1'b0;
    clear_timeout_o = 1'b0;
    clear_busy_o    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (req) begin
          if (stall_q) begin
            state_d = QUIESCE;
          end else if (!fifo_clear_pending_i) begin
            state_d = ISSUE;
          end
        end
      end
      QUIESCE: begin
        if (q_exit) begin
          state_d = fifo_clear_pending_i ? IDLE : ISSUE;
        end
      end
      ISSUE: begin
        fifo_clear_o = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (done_normal || tmo_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        clear_done_o    = 1'b1;
        clear_timeout_o = timeout_q;
        if (rerun && !fifo_clear_pending_i) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the sticky request, rerun, seen, timeout and stall flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      rerun_q   <= 1'b0;
      seen_q    <= 1'b0;
      timeout_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= fifo_valid_o & ~fifo_ready_i;
      case (state_q)
        IDLE: begin
          if (req) begin
            req_q <= 1'b1;
          end
        end
        ISSUE: begin
          req_q     <= 1'b0;
          seen_q    <= fifo_clear_pending_i;
          timeout_q <= 1'b0;
          if (clear_req_i) begin
            rerun_q <= 1'b1;
          end
        end
        WAIT: begin
          seen_q <= seen_q | fifo_clear_pending_i;
          if (clear_req_i) begin
            rerun_q <= 1'b1;
          end
          if (!done_normal && tmo_hit) begin
            timeout_q <= 1'b1;
          end
        end
        DONE: begin
          // A request landing in DONE joins the rerun that is about to start.
          rerun_q <= 1'b0;
          if (rerun && fifo_clear_pending_i) begin
            req_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of clear pulses actually sent to the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if ((state_q == ISSUE) && (count_q != '1)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

endmodule
